// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment debug display: source-mode codes, blank pattern
// and the active-low hex-to-segment table (bit order gfedcba).
package seg_pkg;

   localparam logic [2:0] MODE_PC       = 3'd0;
   localparam logic [2:0] MODE_INSTR    = 3'd1;
   localparam logic [2:0] MODE_REG      = 3'd2;
   localparam logic [2:0] MODE_MEM_ADDR = 3'd3;
   localparam logic [2:0] MODE_MEM_DATA = 3'd4;
   localparam logic [2:0] MODE_DEBUG    = 3'd5;

   localparam logic [7:0] SEG_BLANK = 8'hFF;

   localparam logic [6:0] HEX7_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex7seg.sv
// Combinational nibble-to-segment decoder, active-low gfedcba.
module hex7seg
   import seg_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = HEX7_TABLE[nibble];
   end

endmodule

// File: rtl/seg7_debug_display.sv
// Multiplexed 8-digit hex display of one selectable CPU debug word, with a frame-aligned
// snapshot and an auto-stepping register index for register-file viewing.
module seg7_debug_display
   import seg_pkg::*;
#(
   parameter int SCAN_W = 17,
   parameter int STEP_W = 26
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [2:0]  sw_mode,
   input  logic        sw_hold,
   input  logic [31:0] pc_in,
   input  logic [31:0] instr_in,
   input  logic [31:0] reg_data_in,
   input  logic [31:0] mem_addr_in,
   input  logic [31:0] mem_data_in,
   input  logic [31:0] debug_in,
   output logic [4:0]  reg_sel,
   output logic [7:0]  an,
   output logic [7:0]  seg
);

   logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
   logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
   logic [4:0]        reg_sel_q, reg_sel_d;
   logic [31:0]       snap_q, snap_d;
   logic [7:0]        an_q, an_d;
   logic [7:0]        seg_q, seg_d;

   logic [31:0] src_word;
   logic [2:0]  digit;
   logic        frame_start;
   logic        step_wrap;
   logic [6:0]  nib_seg [8];

   assign digit       = scan_cnt_q[SCAN_W-1 -: 3];
   assign frame_start = (scan_cnt_q == '0);
   assign step_wrap   = (step_cnt_q == '1);

   always_comb begin
      case (sw_mode)
         MODE_PC:       src_word = pc_in;
         MODE_INSTR:    src_word = instr_in;
         MODE_REG:      src_word = reg_data_in;
         MODE_MEM_ADDR: src_word = mem_addr_in;
         MODE_MEM_DATA: src_word = mem_data_in;
         MODE_DEBUG:    src_word = debug_in;
         default:       src_word = '0;
      endcase
   end

   // reg_data_in follows reg_sel_q combinationally, so a capture coinciding with a
   // step naturally holds the word of the index being left.
   always_comb begin
      scan_cnt_d = scan_cnt_q + 1'b1;
      step_cnt_d = step_cnt_q + 1'b1;
      snap_d     = snap_q;
      reg_sel_d  = reg_sel_q;
      if (frame_start && !sw_hold) begin
         snap_d = src_word;
      end
      if (step_wrap && (sw_mode == MODE_REG) && !sw_hold) begin
         reg_sel_d = reg_sel_q + 5'd1;
      end
   end

   // Decoders read the word being captured, so digit 0 of a new frame is never stale.
   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_nib
         hex7seg u_hex7seg (
            .nibble (snap_d[4*gi +: 4]),
            .seg_n  (nib_seg[gi])
         );
      end
   endgenerate

   always_comb begin
      an_d  = ~(8'b1 << digit);
      seg_d = {~(sw_hold && (digit == 3'd0)), nib_seg[digit]};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         scan_cnt_q <= '0;
         step_cnt_q <= '0;
         reg_sel_q  <= '0;
         snap_q     <= '0;
         an_q       <= SEG_BLANK;
         seg_q      <= SEG_BLANK;
      end else begin
         scan_cnt_q <= scan_cnt_d;
         step_cnt_q <= step_cnt_d;
         reg_sel_q  <= reg_sel_d;
         snap_q     <= snap_d;
         an_q       <= an_d;
         seg_q      <= seg_d;
      end
   end

   assign reg_sel = reg_sel_q;
   assign an      = an_q;
   assign seg     = seg_q;

endmodule

// File: tb/tb_seg7_debug_display.sv
// Randomized self-checking bench for seg7_debug_display with a cycle-count based model.
module tb_seg7_debug_display;

   localparam int SCAN_W = 6;
   localparam int STEP_W = 4;

   logic        clk = 1'b0;
   logic        rstn;
   logic [2:0]  sw_mode;
   logic        sw_hold;
   logic [31:0] pc_in, instr_in, reg_data_in, mem_addr_in, mem_data_in, debug_in;
   logic [4:0]  reg_sel;
   logic [7:0]  an, seg;

   logic [31:0] regfile [32];
   assign reg_data_in = regfile[reg_sel];

   int errors = 0;
   int checks = 0;

   seg7_debug_display #(.SCAN_W(SCAN_W), .STEP_W(STEP_W)) dut (
      .clk         (clk),
      .rstn        (rstn),
      .sw_mode     (sw_mode),
      .sw_hold     (sw_hold),
      .pc_in       (pc_in),
      .instr_in    (instr_in),
      .reg_data_in (reg_data_in),
      .mem_addr_in (mem_addr_in),
      .mem_data_in (mem_data_in),
      .debug_in    (debug_in),
      .reg_sel     (reg_sel),
      .an          (an),
      .seg         (seg)
   );

   always #5 clk = ~clk;

   // Reference model: m_t counts clocks since reset; frame = 64 clks, digit = 8 clks,
   // register step every 16 clks.
   logic [6:0]  hex_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
   int          m_t;
   logic [4:0]  m_reg_sel;
   logic [31:0] m_snap;
   logic [7:0]  m_an, m_seg;

   function automatic logic [31:0] source_word(input logic [2:0] m, input logic [4:0] rs);
      case (m)
         3'd0:    return pc_in;
         3'd1:    return instr_in;
         3'd2:    return regfile[rs];
         3'd3:    return mem_addr_in;
         3'd4:    return mem_data_in;
         3'd5:    return debug_in;
         default: return 32'h0;
      endcase
   endfunction

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         m_t       <= 0;
         m_reg_sel <= 5'd0;
         m_snap    <= 32'h0;
         m_an      <= 8'hFF;
         m_seg     <= 8'hFF;
      end else begin : model_step
         int          pos;
         int          dg;
         logic [31:0] shown;
         logic [3:0]  nib;
         pos   = m_t % 64;
         dg    = pos / 8;
         shown = m_snap;
         if (pos == 0 && !sw_hold) shown = source_word(sw_mode, m_reg_sel);
         nib   = shown[4*dg +: 4];
         m_snap <= shown;
         m_an   <= ~(8'd1 << dg);
         m_seg  <= {~(sw_hold && dg == 0), hex_ref[nib]};
         if ((m_t % 16) == 15 && sw_mode == 3'd2 && !sw_hold)
            m_reg_sel <= 5'((int'(m_reg_sel) + 1) % 32);
         m_t <= m_t + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model.
   always @(posedge clk) begin
      #2;
      check("an", {24'h0, an}, {24'h0, m_an});
      check("seg", {24'h0, seg}, {24'h0, m_seg});
      check("reg_sel", {27'h0, reg_sel}, {27'h0, m_reg_sel});
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_phase(input int target);
      int k;
      k = 0;
      while ((m_t % 64) != target && k < 200) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (k >= 200) begin
         errors++;
         $display("FAIL wait_phase: phase %0d, expected %0d", m_t % 64, target);
      end
   endtask

   task automatic randomize_data();
      pc_in       = $urandom;
      instr_in    = $urandom;
      mem_addr_in = $urandom;
      mem_data_in = $urandom;
      debug_in    = $urandom;
      regfile[$urandom_range(0, 31)] = $urandom;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) regfile[i] = $urandom;
      rstn    = 1'b0;
      sw_mode = 3'd0;
      sw_hold = 1'b0;
      randomize_data();
      pc_in   = 32'h0000_1A2F;

      cyc(3);
      check("rst_an", {24'h0, an}, 32'hFF);
      check("rst_seg", {24'h0, seg}, 32'hFF);
      check("rst_reg_sel", {27'h0, reg_sel}, 32'h0);
      rstn = 1'b1;
      $display("txn reset released");

      cyc(1);
      check("d0_an", {24'h0, an}, 32'hFE);
      check("d0_seg", {24'h0, seg}, 32'h8E);
      cyc(8);
      check("d1_an", {24'h0, an}, 32'hFD);
      check("d1_seg", {24'h0, seg}, 32'hA4);
      cyc(8);
      check("d2_an", {24'h0, an}, 32'hFB);
      check("d2_seg", {24'h0, seg}, 32'h88);
      cyc(8);
      check("d3_an", {24'h0, an}, 32'hF7);
      check("d3_seg", {24'h0, seg}, 32'hF9);
      cyc(8);
      check("d4_an", {24'h0, an}, 32'hEF);
      check("d4_seg", {24'h0, seg}, 32'hC0);
      $display("txn frame pc=00001a2f");

      pc_in = 32'h0000_0003;
      cyc(32);
      check("next_d0_an", {24'h0, an}, 32'hFE);
      check("next_d0_seg", {24'h0, seg}, 32'hB0);
      $display("txn mid-frame pc change");

      sw_mode = 3'd2;
      cyc(510);
      check("step31", {27'h0, reg_sel}, 32'd31);
      cyc(1);
      check("step_wrap", {27'h0, reg_sel}, 32'd0);
      cyc(20);
      check("step_one", {27'h0, reg_sel}, 32'd1);
      sw_mode = 3'd0;
      cyc(100);
      check("reg_frozen", {27'h0, reg_sel}, 32'd1);
      $display("txn reg stepping");

      sw_hold = 1'b1;
      sw_mode = 3'd2;
      cyc(9);
      check("dp_held", {31'h0, seg[7]}, 32'd0);
      check("dp_held_an", {24'h0, an}, 32'hFE);
      for (int i = 0; i < 192; i++) begin
         sw_mode = 3'($urandom_range(0, 7));
         randomize_data();
         cyc(1);
      end
      check("hold_reg_sel", {27'h0, reg_sel}, 32'd1);
      check("hold_dp_again", {31'h0, seg[7]}, 32'd0);
      sw_hold = 1'b0;
      $display("txn hold across 3 frames");

      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 15) == 0) sw_mode = 3'($urandom_range(0, 7));
         if ($urandom_range(0, 3) == 0) sw_mode = 3'd2;
         sw_hold = ($urandom_range(0, 9) == 0);
         randomize_data();
         cyc(1);
      end
      $display("txn random run done");

      sw_hold = 1'b0;
      sw_mode = 3'd6;
      pc_in   = 32'hDEAD_BEEF;
      cyc(64);
      wait_phase(1);
      for (int i = 0; i < 8; i++) begin
         check("mode6_seg", {24'h0, seg}, 32'hC0);
         cyc(8);
      end
      $display("txn mode 6 blank-zero frame");

      wait_phase(26);
      @(posedge clk);
      #3 rstn = 1'b0;
      #1;
      check("async_an", {24'h0, an}, 32'hFF);
      check("async_seg", {24'h0, seg}, 32'hFF);
      check("async_reg_sel", {27'h0, reg_sel}, 32'h0);
      @(negedge clk);
      cyc(2);
      rstn = 1'b1;
      cyc(1);
      check("restart_an", {24'h0, an}, 32'hFE);
      cyc(20);
      $display("txn async reset mid-digit");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
